// File: rtl/pipe_control_unit.sv
// Pipelined control unit: RV32I main/ALU decode, ID/EX control register with
// stall/flush, and a sequencer for the multi-cycle custom CNN instruction.
module pipe_control_unit #(
  parameter logic [6:0]  CNN_OPCODE = 7'b0001011,
  parameter bit          ENABLE_CNN = 1'b1,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       instr_valid,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       stallE,
  input  logic       flushE,
  input  logic       flushD,
  input  logic       acc_ready,
  input  logic       acc_done,
  output logic       RegWriteE,
  output logic       MemWriteE,
  output logic       BranchE,
  output logic       JumpE,
  output logic [1:0] ResultSrcE,
  output logic [1:0] ALUSrcAE,
  output logic [1:0] ALUSrcBE,
  output logic [2:0] ALUControlE,
  output logic [2:0] ImmSrcD,
  output logic       cnn_start,
  output logic       stall_req,
  output logic       cnn_err
);

  localparam int unsigned     CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
  } ctrl_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  ctrl_t            main_word;
  ctrl_t            dec_word;
  ctrl_t            load_word;
  ctrl_t            ctrl_d, ctrl_q;
  logic [1:0]       alu_op;
  logic [2:0]       imm_src;
  logic [2:0]       alu_control;
  logic             is_cnn;
  state_t           state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             kill_d, kill_q;
  logic             err_d, err_q;

  assign is_cnn = ENABLE_CNN && instr_valid && (opcode == CNN_OPCODE);

  // Main decode: opcode to control fields, immediate format and ALUOp
  always_comb begin
    main_word = '0;
    imm_src   = 3'b000;
    alu_op    = 2'b00;
    case (opcode)
      OP_LOAD: begin
        main_word.reg_write  = 1'b1;
        main_word.alu_src_b  = 2'b01;
        main_word.result_src = 2'b01;
      end
      OP_STORE: begin
        imm_src              = 3'b001;
        main_word.alu_src_b  = 2'b01;
        main_word.mem_write  = 1'b1;
      end
      OP_R: begin
        main_word.reg_write  = 1'b1;
        alu_op               = 2'b10;
      end
      OP_B: begin
        imm_src              = 3'b010;
        main_word.branch     = 1'b1;
        alu_op               = 2'b01;
      end
      OP_I: begin
        main_word.reg_write  = 1'b1;
        main_word.alu_src_b  = 2'b01;
        alu_op               = 2'b10;
      end
      OP_JAL: begin
        main_word.reg_write  = 1'b1;
        imm_src              = 3'b011;
        main_word.result_src = 2'b10;
        main_word.jump       = 1'b1;
      end
      OP_JALR: begin
        main_word.reg_write  = 1'b1;
        main_word.alu_src_b  = 2'b01;
        main_word.result_src = 2'b10;
        main_word.jump       = 1'b1;
      end
      OP_LUI: begin
        main_word.reg_write  = 1'b1;
        imm_src              = 3'b100;
        main_word.alu_src_a  = 2'b10;
        main_word.alu_src_b  = 2'b01;
      end
      OP_AUIPC: begin
        main_word.reg_write  = 1'b1;
        imm_src              = 3'b100;
        main_word.alu_src_a  = 2'b01;
        main_word.alu_src_b  = 2'b01;
      end
      default: begin
        main_word = '0;
      end
    endcase
  end

  // ALU decode: ALUOp plus funct3/funct7b5 to ALU operation
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      2'b00: alu_control = ALU_ADD;
      2'b01: alu_control = ALU_SUB;
      2'b10: begin
        case (funct3)
          3'b000:  alu_control = ((opcode == OP_R) && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control = ALU_SLL;
          3'b010:  alu_control = ALU_SLT;
          3'b100:  alu_control = ALU_XOR;
          3'b101:  alu_control = ALU_SRL;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

  // Merge the two decode halves into one control word
  always_comb begin
    dec_word             = main_word;
    dec_word.alu_control = alu_control;
  end

  // CNN sequencer next state; also selects what the ID/EX register would load
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    kill_d    = kill_q;
    err_d     = err_q;
    cnn_start = 1'b0;
    stall_req = 1'b0;
    load_word = '0;
    case (state_q)
      S_IDLE: begin
        if (instr_valid && !flushD && !is_cnn) begin
          load_word = dec_word;
        end
        if (is_cnn && !flushD) begin
          state_d   = S_ISSUE;
          stall_req = 1'b1;
        end
      end
      S_ISSUE: begin
        cnn_start = 1'b1;
        stall_req = 1'b1;
        // A squash arriving with the handshake cannot cancel the transfer,
        // so the operation proceeds and only its writeback is dropped.
        if (acc_ready) begin
          state_d = S_WAIT;
          cnt_d   = '0;
          kill_d  = flushD;
        end else if (flushD) begin
          state_d = S_IDLE;
          kill_d  = 1'b0;
        end
      end
      S_WAIT: begin
        stall_req = 1'b1;
        cnt_d     = cnt_q + 1'b1;
        if (flushD) begin
          kill_d = 1'b1;
        end
        if (acc_done) begin
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          kill_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        if (!stallE) begin
          if (!kill_q) begin
            load_word.reg_write  = 1'b1;
            load_word.result_src = 2'b11;
          end
          kill_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ID/EX control register next value: flush beats stall beats load
  always_comb begin
    ctrl_d = ctrl_q;
    if (flushE) begin
      ctrl_d = '0;
    end else if (!stallE) begin
      ctrl_d = load_word;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q  <= '0;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      kill_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kill_q  <= kill_d;
      err_q   <= err_d;
    end
  end

  assign RegWriteE   = ctrl_q.reg_write;
  assign MemWriteE   = ctrl_q.mem_write;
  assign BranchE     = ctrl_q.branch;
  assign JumpE       = ctrl_q.jump;
  assign ResultSrcE  = ctrl_q.result_src;
  assign ALUSrcAE    = ctrl_q.alu_src_a;
  assign ALUSrcBE    = ctrl_q.alu_src_b;
  assign ALUControlE = ctrl_q.alu_control;
  assign ImmSrcD     = imm_src;
  assign cnn_err     = err_q;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Self-checking bench for pipe_control_unit: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_pipe_control_unit;

  localparam int unsigned TO  = 8;
  localparam logic [6:0]  CNN = 7'b0001011;

  logic       clk = 1'b0;
  logic       reset, instr_valid, funct7b5, stallE, flushE, flushD, acc_ready, acc_done;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       RegWriteE, MemWriteE, BranchE, JumpE, cnn_start, stall_req, cnn_err;
  logic [1:0] ResultSrcE, ALUSrcAE, ALUSrcBE;
  logic [2:0] ALUControlE, ImmSrcD;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  pipe_control_unit #(
    .CNN_OPCODE(CNN),
    .ENABLE_CNN(1'b1),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .opcode(opcode),
    .funct3(funct3), .funct7b5(funct7b5), .stallE(stallE), .flushE(flushE),
    .flushD(flushD), .acc_ready(acc_ready), .acc_done(acc_done),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchE(BranchE), .JumpE(JumpE),
    .ResultSrcE(ResultSrcE), .ALUSrcAE(ALUSrcAE), .ALUSrcBE(ALUSrcBE),
    .ALUControlE(ALUControlE), .ImmSrcD(ImmSrcD), .cnn_start(cnn_start),
    .stall_req(stall_req), .cnn_err(cnn_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int rw, mw, br, jp, rs, asa, asb, alu;
  } ew_t;

  localparam ew_t NOP = '{default: 0};
  int alu_by_f3[8] = '{0, 6, 5, 0, 4, 7, 3, 2};

  function automatic ew_t decode(input logic [6:0] opc, input logic [2:0] f3, input logic f7);
    ew_t w = '{default: 0};
    int aluop = 0;
    case (opc)
      7'b0000011: begin w.rw = 1; w.asb = 1; w.rs = 1; end
      7'b0100011: begin w.mw = 1; w.asb = 1; end
      7'b0110011: begin w.rw = 1; aluop = 2; end
      7'b1100011: begin w.br = 1; aluop = 1; end
      7'b0010011: begin w.rw = 1; w.asb = 1; aluop = 2; end
      7'b1101111: begin w.rw = 1; w.rs = 2; w.jp = 1; end
      7'b1100111: begin w.rw = 1; w.asb = 1; w.rs = 2; w.jp = 1; end
      7'b0110111: begin w.rw = 1; w.asa = 2; w.asb = 1; end
      7'b0010111: begin w.rw = 1; w.asa = 1; w.asb = 1; end
      default: ;
    endcase
    if (aluop == 1) w.alu = 1;
    else if (aluop == 2) begin
      w.alu = alu_by_f3[f3];
      if (f3 == 3'd0 && opc == 7'b0110011 && f7) w.alu = 1;
    end
    return w;
  endfunction

  function automatic int imm_of(input logic [6:0] opc);
    case (opc)
      7'b0100011: return 1;
      7'b1100011: return 2;
      7'b1101111: return 3;
      7'b0110111, 7'b0010111: return 4;
      default: return 0;
    endcase
  endfunction

  ew_t m_e = NOP;
  bit  m_iss = 0, m_wt = 0, m_dn = 0, m_kill = 0, m_err = 0;
  int  m_wait = 0;

  // model advance on each rising edge using the inputs held across it
  always @(posedge clk) begin : model
    ew_t nxt;
    bit  cnn_now, idle;
    if (reset) begin
      m_e = NOP; m_iss = 0; m_wt = 0; m_dn = 0; m_kill = 0; m_err = 0; m_wait = 0;
    end else begin
      cnn_now = instr_valid && (opcode == CNN);
      idle    = !(m_iss || m_wt || m_dn);
      nxt     = NOP;
      if (idle && instr_valid && !flushD && !cnn_now) nxt = decode(opcode, funct3, funct7b5);
      if (m_dn && !m_kill) begin nxt.rw = 1; nxt.rs = 3; end
      if (flushE) m_e = NOP;
      else if (!stallE) m_e = nxt;

      if (idle) begin
        if (cnn_now && !flushD) m_iss = 1;
      end else if (m_iss) begin
        if (acc_ready) begin m_iss = 0; m_wt = 1; m_wait = 0; m_kill = flushD; end
        else if (flushD) m_iss = 0;
      end else if (m_wt) begin
        if (flushD) m_kill = 1;
        if (acc_done) begin m_wt = 0; m_dn = 1; end
        else begin
          m_wait++;
          if (m_wait == TO) begin m_wt = 0; m_err = 1; m_kill = 0; end
        end
      end else if (!stallE) begin
        m_dn = 0; m_kill = 0;
      end
    end
  end

  // compare process: every cycle, mid-period
  always @(negedge clk) begin : compare
    bit idle, cnn_now;
    if (chk_en) begin
      idle    = !(m_iss || m_wt || m_dn);
      cnn_now = instr_valid && (opcode == CNN);
      chk("RegWriteE",   RegWriteE,   m_e.rw);
      chk("MemWriteE",   MemWriteE,   m_e.mw);
      chk("BranchE",     BranchE,     m_e.br);
      chk("JumpE",       JumpE,       m_e.jp);
      chk("ResultSrcE",  ResultSrcE,  m_e.rs);
      chk("ALUSrcAE",    ALUSrcAE,    m_e.asa);
      chk("ALUSrcBE",    ALUSrcBE,    m_e.asb);
      chk("ALUControlE", ALUControlE, m_e.alu);
      chk("ImmSrcD",     ImmSrcD,     imm_of(opcode));
      chk("cnn_start",   cnn_start,   m_iss);
      chk("stall_req",   stall_req,   m_iss || m_wt || (idle && cnn_now && !flushD));
      chk("cnn_err",     cnn_err,     m_err);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [6:0] opc, input logic [2:0] f3, input logic f7);
    instr_valid = v; opcode = opc; funct3 = f3; funct7b5 = f7;
  endtask

  logic [6:0] ops[10] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b1100011, 7'b0010011,
                          7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, CNN};

  initial begin
    reset = 1'b1; stallE = 0; flushE = 0; flushD = 0; acc_ready = 0; acc_done = 0;
    drive(0, 7'd0, 3'd0, 0);
    step();
    chk_en = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_regwrite", RegWriteE, 0);
    chk("rst_resultsrc", ResultSrcE, 0);
    chk("rst_err", cnn_err, 0);
    chk("rst_stall", stall_req, 0);

    // R-type sub
    drive(1, 7'b0110011, 3'd0, 1);
    step();
    chk("rsub_rw", RegWriteE, 1);
    chk("rsub_alu", ALUControlE, 1);
    chk("rsub_srcb", ALUSrcBE, 0);

    // LUI then AUIPC
    drive(1, 7'b0110111, 3'b101, 0); #1;
    chk("lui_imm", ImmSrcD, 4);
    step();
    chk("lui_srca", ALUSrcAE, 2);
    chk("lui_srcb", ALUSrcBE, 1);
    chk("lui_alu", ALUControlE, 0);
    drive(1, 7'b0010111, 3'b110, 1); #1;
    chk("auipc_imm", ImmSrcD, 4);
    step();
    chk("auipc_srca", ALUSrcAE, 1);
    chk("auipc_srcb", ALUSrcBE, 1);

    // stall holds AUIPC word while an AND is presented, then flush beats stall
    drive(1, 7'b0110011, 3'b111, 0);
    stallE = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_srca", ALUSrcAE, 1);
      chk("stall_alu", ALUControlE, 0);
    end
    flushE = 1;
    step();
    chk("flush_rw", RegWriteE, 0);
    chk("flush_srca", ALUSrcAE, 0);
    flushE = 0; stallE = 0;

    // CNN op: ready after 2 ISSUE cycles, done later
    drive(1, CNN, 3'd0, 0); #1;
    chk("cnn_idle_stall", stall_req, 1);
    chk("cnn_idle_start", cnn_start, 0);
    step();
    chk("cnn_issue1_start", cnn_start, 1);
    step();
    chk("cnn_issue2_start", cnn_start, 1);
    acc_ready = 1;
    step();
    acc_ready = 0; #1;
    for (int i = 0; i < 3; i++) begin
      chk("cnn_wait_stall", stall_req, 1);
      chk("cnn_wait_start", cnn_start, 0);
      step();
    end
    acc_done = 1;
    step();
    acc_done = 0; #1;
    chk("cnn_done_stall", stall_req, 0);
    chk("cnn_done_start", cnn_start, 0);
    step();
    drive(0, 7'd0, 3'd0, 0); #1;
    chk("cnn_wb_rw", RegWriteE, 1);
    chk("cnn_wb_rs", ResultSrcE, 3);
    chk("cnn_wb_srcb", ALUSrcBE, 0);
    step();

    // timeout: acc_done never arrives
    drive(1, CNN, 3'd0, 0);
    step();
    acc_ready = 1;
    step();
    acc_ready = 0;
    drive(0, 7'd0, 3'd0, 0); #1;
    for (int i = 0; i < int'(TO); i++) begin
      chk("to_wait_stall", stall_req, 1);
      chk("to_wait_err", cnn_err, 0);
      step();
    end
    #1;
    chk("to_err", cnn_err, 1);
    chk("to_stall", stall_req, 0);
    chk("to_start", cnn_start, 0);
    repeat (3) step();
    chk("to_err_sticky", cnn_err, 1);
    reset = 1;
    step();
    reset = 0;
    chk("to_err_cleared", cnn_err, 0);

    // flushD during WAIT kills the writeback
    drive(1, CNN, 3'd0, 0);
    step();
    acc_ready = 1;
    step();
    acc_ready = 0; flushD = 1;
    drive(0, 7'd0, 3'd0, 0);
    step();
    flushD = 0;
    step();
    acc_done = 1;
    step();
    acc_done = 0;
    step();
    chk("kill_rw", RegWriteE, 0);
    chk("kill_rs", ResultSrcE, 0);

    // flushD in ISSUE without ready aborts
    drive(1, CNN, 3'd0, 0);
    step();
    flushD = 1; #1;
    chk("abort_start_before", cnn_start, 1);
    step();
    flushD = 0;
    drive(0, 7'd0, 3'd0, 0); #1;
    chk("abort_start_after", cnn_start, 0);
    chk("abort_stall_after", stall_req, 0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int k;
      k = int'($urandom_range(0, 10));
      reset       = ($urandom_range(0, 99) < 1);
      instr_valid = ($urandom_range(0, 99) < 80);
      opcode      = (k == 10) ? 7'($urandom) : ops[k];
      funct3      = 3'($urandom);
      funct7b5    = 1'($urandom);
      stallE      = ($urandom_range(0, 99) < 15);
      flushE      = ($urandom_range(0, 99) < 8);
      flushD      = ($urandom_range(0, 99) < 8);
      acc_ready   = ($urandom_range(0, 99) < 40);
      acc_done    = ($urandom_range(0, 99) < 25);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_control_unit.md
Name: pipe_control_unit

Overview:
- Successor to the combinational opcode decoder: combines main decode and ALU decode into one block.
- Decodes RV32I control (adds LUI and AUIPC) and registers the control word into the ID/EX stage, with stall and flush.
- Sequences a multi-cycle custom CNN instruction through an FSM with a request/ack/done handshake to the CNN accelerator.
- Sits between the decode stage, the hazard unit and the accelerator.

Parameters:
- CNN_OPCODE, 7'b0001011, opcode of the custom CNN instruction (custom-0).
- ENABLE_CNN, 1, 0 treats CNN_OPCODE as illegal (decodes to NOP, no FSM activity).
- TIMEOUT, 255, max WAIT cycles before abort; counter width = $clog2(TIMEOUT+1).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- instr_valid  in  1  decode-stage instruction valid.
- opcode  in  7  instr[6:0].
- funct3  in  3  instr[14:12].
- funct7b5  in  1  instr[30].
- stallE  in  1  hold the ID/EX control register.
- flushE  in  1  load NOP into the ID/EX control register.
- flushD  in  1  squash the decode-stage instruction (taken branch/jump).
- acc_ready  in  1  accelerator accepts start.
- acc_done  in  1  accelerator result valid (1-cycle pulse).
- RegWriteE  out  1  registered control.
- MemWriteE  out  1  registered control.
- BranchE  out  1  registered control.
- JumpE  out  1  registered control.
- ResultSrcE  out  2  00 ALU, 01 mem, 10 PC+4, 11 accelerator result.
- ALUSrcAE  out  2  00 rs1, 01 PC, 10 zero.
- ALUSrcBE  out  2  00 rs2, 01 imm.
- ALUControlE  out  3  registered ALU operation.
- ImmSrcD  out  3  combinational, to the immediate extender: 000 I, 001 S, 010 B, 011 J, 100 U.
- cnn_start  out  1  request to accelerator.
- stall_req  out  1  to hazard unit: stall fetch/decode.
- cnn_err  out  1  sticky timeout flag.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high.
- Reset values: all E outputs 0 (NOP), cnn_start 0, stall_req 0, cnn_err 0, FSM in IDLE, timeout counter 0.
- Decode table (RegWrite, ImmSrc, ALUSrcA, ALUSrcB, MemWrite, ResultSrc, Branch, ALUOp, Jump):
  - Load 0000011: 1, 000, 00, 01, 0, 01, 0, 00, 0
  - Store 0100011: 0, 001, 00, 01, 1, 00, 0, 00, 0
  - R 0110011: 1, 000, 00, 00, 0, 00, 0, 10, 0
  - B 1100011: 0, 010, 00, 00, 0, 00, 1, 01, 0
  - I 0010011: 1, 000, 00, 01, 0, 00, 0, 10, 0
  - JAL 1101111: 1, 011, 00, 00, 0, 10, 0, 00, 1
  - JALR 1100111: 1, 000, 00, 01, 0, 10, 0, 00, 1
  - LUI 0110111: 1, 100, 10, 01, 0, 00, 0, 00, 0
  - AUIPC 0010111: 1, 100, 01, 01, 0, 00, 0, 00, 0
  - Others: all zero.
- ALU decode:
  - ALUOp 00 gives add 000; 01 gives sub 001.
  - ALUOp 10 uses funct3: 000 gives sub if R-type and funct7b5, else add; 001 sll 110; 010 slt 101; 100 xor 100; 101 srl 111; 110 or 011; 111 and 010; 011 gives add.
- ID/EX register priority: reset > flushE (NOP) > stallE (hold) > load.
  - Load value is the decoded word if instr_valid, not flushD, and not a CNN op; otherwise NOP.
  - Decode-to-E latency is 1 cycle.
- CNN FSM, states IDLE, ISSUE, WAIT, DONE:
  - IDLE: valid CNN op and no flushD → ISSUE; stall_req asserts combinationally in that same cycle. E register loads NOP.
  - ISSUE: cnn_start=1 and stall_req=1. acc_ready=1 → WAIT and counter cleared. flushD=1 with acc_ready=0 → IDLE, no transfer. If both are 1, the handshake wins and kill is set.
  - WAIT: stall_req=1, counter increments each cycle. acc_done → DONE. Counter reaches TIMEOUT → set cnn_err (sticky until reset), go to IDLE, issue NOP.
    - flushD in WAIT sets kill; the operation still completes.
  - DONE: stall_req=0. If not stallE: E loads RegWrite=1, ResultSrc=11, other fields 0 (or NOP if kill). Clear kill, go to IDLE.
    - stallE in DONE holds DONE.
- cnn_start is high only in ISSUE.
- acc_done outside WAIT is ignored.
- reset mid-operation returns the FSM to IDLE and drops cnn_start the next edge.

Test Plan:
- R-type funct3=000 funct7b5=1 with instr_valid → next edge RegWriteE=1, ALUControlE=001, ALUSrcBE=00.
- LUI then AUIPC → ALUSrcAE=10 then 01, ALUSrcBE=01, ImmSrcD=100, ALUControlE=000.
- stallE held 3 cycles with a new opcode presented → outputs unchanged. Then flushE with stallE both 1 → NOP.
- CNN op, acc_ready after 2 cycles, acc_done after 5 → stall_req high through WAIT, cnn_start high only in ISSUE, then one DONE cycle with RegWriteE=1, ResultSrcE=11.
- TIMEOUT=8, acc_done never → cnn_err=1 after 8 WAIT cycles, FSM in IDLE, stall_req=0. cnn_err stays 1 until reset.
- flushD during WAIT, then acc_done → DONE issues NOP (RegWriteE=0). flushD in ISSUE with acc_ready=0 → IDLE, cnn_start drops.
